shift_req_queue: RTL and testbench

- Request buffer that sits directly upstream of the 32-bit combinational logical right shifter (inputs A, cnt; output B).
- Queues {operand, shift count} requests behind a valid/ready handshake.
- Holds the head request stable on the shifter inputs, then registers the shifter result into a valid/ready output stage.
- The shifter stays purely combinational; this block provides all timing, buffering and back-pressure.

---
 rtl/shift_pkg.sv | 17 +
 rtl/shift_req_fifo.sv | 64 ++++++
 rtl/shift_req_queue.sv | 107 ++++++++++
 tb/tb_shift_req_queue.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared widths, request record and level-width helper for the shift request queue.
package shift_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 5;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CNT_W-1:0]  cnt;
  } shift_req_t;

  // Occupancy needs one extra bit so a full queue (level == DEPTH) is representable.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/shift_req_fifo.sv
// Generic power-of-2 request FIFO: storage, wrapping pointers, occupancy and full/empty.
module shift_req_fifo
  import shift_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_flush,
  input  logic                        i_push,
  input  shift_req_t                  i_push_data,
  input  logic                        i_pop,
  output shift_req_t                  o_head,
  output logic [level_w(DEPTH)-1:0]   o_level,
  output logic                        o_full,
  output logic                        o_empty
);

  localparam int LW = level_w(DEPTH);
  localparam int PW = $clog2(DEPTH);

  shift_req_t        r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [LW-1:0]     r_level;
  logic              w_push;
  logic              w_pop;

  assign o_full  = (r_level == LW'(DEPTH));
  assign o_empty = (r_level == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Head is forced to zero when empty so the downstream shifter idles at a known value.
  assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];
  assign o_level = r_level;

  always_ff @(posedge clk) begin
    if (w_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_level <= r_level + LW'(w_push) - LW'(w_pop);
    end
  end

endmodule

// File: rtl/shift_req_queue.sv
// Request queue and registered output stage around an external combinational right shifter.
// Optional statistics counters are enabled with the SHIFT_REQ_STATS_EN macro.
module shift_req_queue
  import shift_pkg::*;
#(
  parameter int DATA_W = shift_pkg::DATA_W,
  parameter int CNT_W  = shift_pkg::CNT_W,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  input  logic [CNT_W-1:0]           in_cnt,
  output logic [DATA_W-1:0]          shf_a,
  output logic [CNT_W-1:0]           shf_cnt,
  input  logic [DATA_W-1:0]          shf_b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [level_w(DEPTH)-1:0]  level
`ifdef SHIFT_REQ_STATS_EN
  ,
  output logic [15:0]                req_count,
  output logic [15:0]                stall_count
`endif
);

  shift_req_t                 w_push_req;
  shift_req_t                 w_head;
  logic                       w_full;
  logic                       w_empty;
  logic                       w_push;
  logic                       w_pop;
  logic                       r_out_valid;
  logic [DATA_W-1:0]          r_out_data;

  assign w_push_req = '{data: in_data, cnt: in_cnt};

  // in_ready depends on registered occupancy only, so a full queue refuses even while popping.
  assign in_ready = !w_full;
  assign w_push   = in_valid && !w_full && !flush;
  assign w_pop    = !w_empty && (!r_out_valid || out_ready) && !flush;

  shift_req_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_flush     (flush),
    .i_push      (w_push),
    .i_push_data (w_push_req),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_level     (level),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  assign shf_a   = w_head.data;
  assign shf_cnt = w_head.cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_pop) begin
      r_out_valid <= 1'b1;
      r_out_data  <= shf_b;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

`ifdef SHIFT_REQ_STATS_EN
  logic [15:0] r_req_count;
  logic [15:0] r_stall_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_count   <= '0;
      r_stall_count <= '0;
    end else if (flush) begin
      r_req_count   <= '0;
      r_stall_count <= '0;
    end else begin
      if (w_push && (r_req_count != 16'hFFFF)) begin
        r_req_count <= r_req_count + 16'd1;
      end
      if (in_valid && w_full && (r_stall_count != 16'hFFFF)) begin
        r_stall_count <= r_stall_count + 16'd1;
      end
    end
  end

  assign req_count   = r_req_count;
  assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_shift_req_queue.sv
// Directed bench for shift_req_queue: vector table plus hand-written flush, streaming and reset sequences.
module tb_shift_req_queue;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_cnt;
  logic [31:0] shf_a;
  logic [4:0]  shf_cnt;
  logic [31:0] shf_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [2:0]  level;
`ifdef SHIFT_REQ_STATS_EN
  logic [15:0] req_count;
  logic [15:0] stall_count;
`endif

  int checks;
  int failures;

  // Stand-in for the combinational shifter that sits downstream.
  assign shf_b = shf_a >> shf_cnt;

  shift_req_queue dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_cnt    (in_cnt),
    .shf_a     (shf_a),
    .shf_cnt   (shf_cnt),
    .shf_b     (shf_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .level     (level)
`ifdef SHIFT_REQ_STATS_EN
    ,
    .req_count   (req_count),
    .stall_count (stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [31:0] id;
    logic [4:0]  ic;
    logic        ordy;
    logic        e_ov;
    logic [31:0] e_od;
    logic [2:0]  e_lvl;
    logic        e_rdy;
    logic [31:0] e_sa;
    logic [4:0]  e_sc;
  } vec_t;

  vec_t vt [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [31:0] d, input logic [4:0] c, input logic ordy);
    in_valid  = iv;
    in_data   = d;
    in_cnt    = c;
    out_ready = ordy;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 1'b0);

    //               iv  id             ic     ordy  e_ov  e_od           lvl   rdy   e_sa           e_sc
    vt[0]  = '{1'b1, 32'h8000_00F0, 5'd4, 1'b1, 1'b0, 32'h0000_0000, 3'd1, 1'b1, 32'h8000_00F0, 5'd4};
    vt[1]  = '{1'b0, 32'h0000_0000, 5'd0, 1'b1, 1'b1, 32'h0800_000F, 3'd0, 1'b1, 32'h0000_0000, 5'd0};
    vt[2]  = '{1'b0, 32'h0000_0000, 5'd0, 1'b1, 1'b0, 32'h0800_000F, 3'd0, 1'b1, 32'h0000_0000, 5'd0};
    vt[3]  = '{1'b1, 32'hFFFF_FFFF, 5'd0, 1'b0, 1'b0, 32'h0800_000F, 3'd1, 1'b1, 32'hFFFF_FFFF, 5'd0};
    vt[4]  = '{1'b1, 32'hFFFF_FFFF, 5'd1, 1'b0, 1'b1, 32'hFFFF_FFFF, 3'd1, 1'b1, 32'hFFFF_FFFF, 5'd1};
    vt[5]  = '{1'b1, 32'hFFFF_FFFF, 5'd2, 1'b0, 1'b1, 32'hFFFF_FFFF, 3'd2, 1'b1, 32'hFFFF_FFFF, 5'd1};
    vt[6]  = '{1'b1, 32'hFFFF_FFFF, 5'd3, 1'b0, 1'b1, 32'hFFFF_FFFF, 3'd3, 1'b1, 32'hFFFF_FFFF, 5'd1};
    vt[7]  = '{1'b1, 32'hFFFF_FFFF, 5'd4, 1'b0, 1'b1, 32'hFFFF_FFFF, 3'd4, 1'b0, 32'hFFFF_FFFF, 5'd1};
    vt[8]  = '{1'b1, 32'h1234_5678, 5'd7, 1'b0, 1'b1, 32'hFFFF_FFFF, 3'd4, 1'b0, 32'hFFFF_FFFF, 5'd1};
    // Full queue with a concurrent pop still refuses the offered request.
    vt[9]  = '{1'b1, 32'hDEAD_BEEF, 5'd0, 1'b1, 1'b1, 32'h7FFF_FFFF, 3'd3, 1'b1, 32'hFFFF_FFFF, 5'd2};
    vt[10] = '{1'b0, 32'h0000_0000, 5'd0, 1'b1, 1'b1, 32'h3FFF_FFFF, 3'd2, 1'b1, 32'hFFFF_FFFF, 5'd3};
    vt[11] = '{1'b0, 32'h0000_0000, 5'd0, 1'b1, 1'b1, 32'h1FFF_FFFF, 3'd1, 1'b1, 32'hFFFF_FFFF, 5'd4};
    vt[12] = '{1'b0, 32'h0000_0000, 5'd0, 1'b1, 1'b1, 32'h0FFF_FFFF, 3'd0, 1'b1, 32'h0000_0000, 5'd0};
    vt[13] = '{1'b0, 32'h0000_0000, 5'd0, 1'b1, 1'b0, 32'h0FFF_FFFF, 3'd0, 1'b1, 32'h0000_0000, 5'd0};

    #12;
    chk("rst_level",     32'(level),     32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  out_data,       32'd0);
    chk("rst_shf_a",     shf_a,          32'd0);
    chk("rst_shf_cnt",   32'(shf_cnt),   32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
`ifdef SHIFT_REQ_STATS_EN
    chk("rst_req_count", 32'(req_count), 32'd0);
`endif
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      drive(vt[i].iv, vt[i].id, vt[i].ic, vt[i].ordy);
      step();
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vt[i].e_ov));
      chk($sformatf("v%0d_out_data", i),  out_data,       vt[i].e_od);
      chk($sformatf("v%0d_level", i),     32'(level),     32'(vt[i].e_lvl));
      chk($sformatf("v%0d_in_ready", i),  32'(in_ready),  32'(vt[i].e_rdy));
      chk($sformatf("v%0d_shf_a", i),     shf_a,          vt[i].e_sa);
      chk($sformatf("v%0d_shf_cnt", i),   32'(shf_cnt),   32'(vt[i].e_sc));
    end

    // Streaming: data = i<<31 (32-bit), cnt = 31, so results alternate 0/1 in acceptance order.
    for (int k = 0; k <= 20; k++) begin
      if (k < 20) drive(1'b1, 32'(k) << 31, 5'd31, 1'b1);
      else        drive(1'b0, 32'h0, 5'd0, 1'b1);
      step();
      chk($sformatf("st%0d_level", k), 32'(level), (k < 20) ? 32'd1 : 32'd0);
      chk($sformatf("st%0d_out_valid", k), 32'(out_valid), (k == 0) ? 32'd0 : 32'd1);
      if (k > 0) chk($sformatf("st%0d_out_data", k), out_data, 32'((k - 1) & 1));
    end
    drive(1'b0, 32'h0, 5'd0, 1'b1);
    step();
    chk("st_drain_out_valid", 32'(out_valid), 32'd0);

    // Flush with a concurrent push: build level=2, out_valid=1 first.
    drive(1'b1, 32'h0000_0011, 5'd0, 1'b0);
    step();
    drive(1'b1, 32'h0000_0022, 5'd0, 1'b0);
    step();
    drive(1'b1, 32'h0000_0033, 5'd0, 1'b0);
    step();
    chk("fl_pre_level",     32'(level),     32'd2);
    chk("fl_pre_out_valid", 32'(out_valid), 32'd1);
    chk("fl_pre_out_data",  out_data,       32'h0000_0011);
    drive(1'b1, 32'h0000_0044, 5'd0, 1'b0);
    flush = 1'b1;
    #1;
    chk("fl_in_ready_same_cycle", 32'(in_ready), 32'd1);
    step();
    flush = 1'b0;
    chk("fl_level",     32'(level),     32'd0);
    chk("fl_out_valid", 32'(out_valid), 32'd0);
    chk("fl_out_data_kept", out_data,   32'h0000_0011);
    chk("fl_shf_a",     shf_a,          32'd0);
`ifdef SHIFT_REQ_STATS_EN
    chk("fl_req_count",   32'(req_count),   32'd0);
    chk("fl_stall_count", 32'(stall_count), 32'd0);
`endif
    drive(1'b0, 32'h0, 5'd0, 1'b1);
    step();
    chk("fl_no_ghost_out_valid", 32'(out_valid), 32'd0);
    chk("fl_no_ghost_level",     32'(level),     32'd0);
    drive(1'b1, 32'h0000_0080, 5'd3, 1'b1);
    step();
    chk("fl_post_shf_a", shf_a, 32'h0000_0080);
    drive(1'b0, 32'h0, 5'd0, 1'b1);
    step();
    chk("fl_post_out_valid", 32'(out_valid), 32'd1);
    chk("fl_post_out_data",  out_data,       32'h0000_0010);
    step();

    // Asynchronous reset in the middle of traffic: 3 queued, result held.
    for (int j = 0; j < 4; j++) begin
      drive(1'b1, 32'hA5A5_0000 | 32'(j), 5'd1, 1'b0);
      step();
    end
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    chk("mr_pre_level",     32'(level),     32'd3);
    chk("mr_pre_out_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_level",     32'(level),     32'd0);
    chk("mr_out_valid", 32'(out_valid), 32'd0);
    chk("mr_shf_a",     shf_a,          32'd0);
    chk("mr_in_ready",  32'(in_ready),  32'd1);
    chk("mr_out_data",  out_data,       32'd0);
    #3;
    rst_n = 1'b1;
    step();
    chk("mr_post_level", 32'(level), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
